// File: rtl/inst_fetch_queue.sv
// Decoupling queue between instruction-fetch handshake and decode.
// Reserves a slot per issued request and discards in-flight data after a flush.
module inst_fetch_queue #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          fetch_issue,
   output logic          fetch_allow,
   input  logic          fetch_data_ok,
   input  logic [31:0]   fetch_pc,
   input  logic [31:0]   fetch_inst,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [31:0]   id_pc,
   output logic [31:0]   id_inst,
   output logic [CW-1:0] count,
   output logic          drop_pending
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] pending;
   logic [CW:0]   reserved;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];

   logic issue_ok;
   logic drop_hit;
   logic push;
   logic pop;

   // A slot is guaranteed for every request counted in outstanding.
   assign reserved    = {1'b0, count} + {1'b0, outstanding};
   assign fetch_allow = reserved < (CW+1)'(DEPTH);
   assign pending     = drop_cnt + outstanding;

   assign issue_ok = fetch_issue && fetch_allow;
   assign drop_hit = fetch_data_ok && (drop_cnt != '0);
   assign push     = fetch_data_ok && (drop_cnt == '0) && (outstanding != '0);
   assign pop      = id_valid && id_ready;

   assign id_valid     = (count != '0);
   assign id_pc        = id_valid ? mem_pc[head]   : '0;
   assign id_inst      = id_valid ? mem_inst[head] : '0;
   assign drop_pending = (drop_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (flush) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         // Everything already in flight belongs to the old stream; a request
         // issued this very cycle belongs to the new one.
         drop_cnt    <= pending - CW'(fetch_data_ok && (pending != '0));
         outstanding <= fetch_issue ? CW'(1) : '0;
      end else begin
         if (push)
            tail <= tail + AW'(1);
         if (pop)
            head <= head + AW'(1);
         if (drop_hit)
            drop_cnt <= drop_cnt - CW'(1);
         count       <= count + CW'(push) - CW'(pop);
         outstanding <= outstanding + CW'(issue_ok) - CW'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_pc[tail]   <= fetch_pc;
         mem_inst[tail] <= fetch_inst;
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: ordering, reservation, wrap, flush, async reset.
module tb_inst_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          fetch_issue;
   logic          fetch_allow;
   logic          fetch_data_ok;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_inst;
   logic          id_valid;
   logic          id_ready;
   logic [31:0]   id_pc;
   logic [31:0]   id_inst;
   logic [CW-1:0] count;
   logic          drop_pending;

   int n_checks;
   int n_fail;
   int accepted;

   inst_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .fetch_issue   (fetch_issue),
      .fetch_allow   (fetch_allow),
      .fetch_data_ok (fetch_data_ok),
      .fetch_pc      (fetch_pc),
      .fetch_inst    (fetch_inst),
      .id_valid      (id_valid),
      .id_ready      (id_ready),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .count         (count),
      .drop_pending  (drop_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      accepted      = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      fetch_issue   = 1'b0;
      fetch_data_ok = 1'b0;
      fetch_pc      = '0;
      fetch_inst    = '0;
      id_ready      = 1'b0;

      #3;
      check("rst_id_valid", id_valid, 0);
      check("rst_count", count, 0);
      check("rst_drop_pending", drop_pending, 0);
      check("rst_fetch_allow", fetch_allow, 1);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_inst", id_inst, 0);
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Two sequential fetches, data one cycle after each issue.
      id_ready    = 1'b1;
      fetch_issue = 1'b1;
      cyc();
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'hBFC0_0000;
      fetch_inst    = 32'h2401_0001;
      check("t1_no_bypass", id_valid, 0);
      cyc();
      check("t1_valid0", id_valid, 1);
      check("t1_pc0", id_pc, 32'hBFC0_0000);
      check("t1_inst0", id_inst, 32'h2401_0001);
      fetch_issue = 1'b0;
      fetch_pc    = 32'hBFC0_0004;
      fetch_inst  = 32'h2402_0002;
      cyc();
      check("t1_valid1", id_valid, 1);
      check("t1_pc1", id_pc, 32'hBFC0_0004);
      check("t1_inst1", id_inst, 32'h2402_0002);
      check("t1_count1", count, 1);
      fetch_data_ok = 1'b0;
      cyc();
      check("t1_empty", id_valid, 0);
      check("t1_count_end", count, 0);

      // Spurious response with nothing outstanding is ignored.
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h0000_0BAD;
      cyc();
      fetch_data_ok = 1'b0;
      check("spur_valid", id_valid, 0);
      check("spur_count", count, 0);

      // Continuous issue with decode stalled: exactly DEPTH accepted.
      id_ready    = 1'b0;
      fetch_issue = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (fetch_allow) accepted++;
         cyc();
      end
      fetch_issue = 1'b0;
      check("t2_accepted", accepted, 4);
      check("t2_allow_low", fetch_allow, 0);
      for (int k = 0; k < 4; k++) begin
         fetch_data_ok = 1'b1;
         fetch_pc      = 32'h100 + 32'(4 * k);
         fetch_inst    = 32'hA0 + 32'(k);
         cyc();
      end
      fetch_data_ok = 1'b0;
      check("t2_count_full", count, 4);
      check("t2_head_pc", id_pc, 32'h100);
      check("t2_allow_full", fetch_allow, 0);

      // Pop from full; an issue in the same cycle is ignored (allow=0).
      id_ready    = 1'b1;
      fetch_issue = 1'b1;
      cyc();
      check("t3_count3", count, 3);
      check("t3_allow_up", fetch_allow, 1);
      check("t3_pc_104", id_pc, 32'h104);
      id_ready = 1'b0;
      cyc();
      fetch_issue = 1'b0;
      check("t3_allow_resv", fetch_allow, 0);
      check("t3_count_hold", count, 3);
      // Push into reserved slot while popping: count unchanged, tail wraps.
      id_ready      = 1'b1;
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h110;
      fetch_inst    = 32'h5;
      cyc();
      fetch_data_ok = 1'b0;
      check("t3_count_pp", count, 3);
      check("t3_pc_108", id_pc, 32'h108);
      check("t3_inst_108", id_inst, 32'hA2);
      cyc();
      check("t3_pc_10c", id_pc, 32'h10C);
      cyc();
      check("t3_pc_110", id_pc, 32'h110);
      check("t3_inst_110", id_inst, 32'h5);
      check("t3_count1", count, 1);
      cyc();
      check("t3_drained", id_valid, 0);

      // Flush with two requests in flight and no data.
      fetch_issue = 1'b1;
      cyc();
      cyc();
      fetch_issue = 1'b0;
      flush       = 1'b1;
      cyc();
      flush = 1'b0;
      check("t4_count", count, 0);
      check("t4_drop_pending", drop_pending, 1);
      check("t4_allow", fetch_allow, 1);
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h4;
      fetch_inst    = 32'hDEAD_BEEF;
      cyc();
      check("t4_drop1_valid", id_valid, 0);
      check("t4_drop1_pending", drop_pending, 1);
      fetch_inst = 32'hCAFE_F00D;
      cyc();
      fetch_data_ok = 1'b0;
      check("t4_drop2_valid", id_valid, 0);
      check("t4_drop2_pending", drop_pending, 0);
      fetch_issue = 1'b1;
      cyc();
      fetch_issue   = 1'b0;
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h8000_0000;
      fetch_inst    = 32'h1234_5678;
      cyc();
      fetch_data_ok = 1'b0;
      check("t4_new_valid", id_valid, 1);
      check("t4_new_pc", id_pc, 32'h8000_0000);
      check("t4_new_inst", id_inst, 32'h1234_5678);
      cyc();
      check("t4_popped", id_valid, 0);

      // Flush coinciding with issue and returning data, one outstanding.
      id_ready    = 1'b0;
      fetch_issue = 1'b1;
      cyc();
      flush         = 1'b1;
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h111;
      fetch_inst    = 32'hDEAD_0001;
      cyc();
      flush         = 1'b0;
      fetch_issue   = 1'b0;
      fetch_data_ok = 1'b0;
      check("t5_valid", id_valid, 0);
      check("t5_drop_pending", drop_pending, 0);
      check("t5_count", count, 0);
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h200;
      fetch_inst    = 32'h22;
      cyc();
      fetch_data_ok = 1'b0;
      check("t5_push_valid", id_valid, 1);
      check("t5_push_pc", id_pc, 32'h200);
      check("t5_push_inst", id_inst, 32'h22);
      id_ready = 1'b1;
      cyc();
      id_ready = 1'b0;
      check("t5_popped", id_valid, 0);

      // Build three entries, then assert reset between clock edges.
      fetch_issue = 1'b1;
      cyc();
      fetch_data_ok = 1'b1;
      fetch_pc      = 32'h300;
      cyc();
      fetch_pc = 32'h304;
      cyc();
      fetch_issue = 1'b0;
      fetch_pc    = 32'h308;
      cyc();
      fetch_data_ok = 1'b0;
      check("t6_count3", count, 3);
      check("t6_head", id_pc, 32'h300);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", id_valid, 0);
      check("t6_rst_count", count, 0);
      check("t6_rst_drop", drop_pending, 0);
      check("t6_rst_allow", fetch_allow, 1);
      check("t6_rst_pc", id_pc, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
